// File: rtl/multiplicador_seq_datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multiplicador_seq_datapath_pkg                               |
// | Description : Shared constants and mode decode for the sequential          |
// |               multiplier datapath and its control decoder.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package multiplicador_seq_datapath_pkg;

  localparam int LARGURA = 8;
  localparam int CNT_W   = 4;

  localparam logic [CNT_W-1:0] CNT_LOAD = '0;
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(LARGURA + 1);

  typedef enum logic [1:0] {
    MODO_LOAD     = 2'd0,
    MODO_CALC     = 2'd1,
    MODO_DONE     = 2'd2,
    MODO_INVALIDO = 2'd3
  } modo_t;

  // Mode the decoder is expected to announce for a given counter value.
  function automatic modo_t modo_esperado(input logic [CNT_W-1:0] cnt);
    modo_t modo;
    if (cnt == CNT_LOAD)     modo = MODO_LOAD;
    else if (cnt == CNT_DONE) modo = MODO_DONE;
    else if (cnt < CNT_DONE)  modo = MODO_CALC;
    else                      modo = MODO_INVALIDO;
    return modo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multiplicador_seq_datapath_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multiplicador_seq_datapath_if                                |
// | Description : Operand/result bus between the ALU operand stack, the        |
// |               multiplier datapath and the result mux.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface multiplicador_seq_datapath_if;
  import multiplicador_seq_datapath_pkg::*;

  logic                   start;
  logic [LARGURA-1:0]     operando_a;
  logic [LARGURA-1:0]     operando_b;
  logic [2*LARGURA-1:0]   produto;
  logic                   busy;
  logic                   pronto;
  logic                   erro_seq;

  // Requesting side (operand stack / result consumer).
  modport master (
    output start, operando_a, operando_b,
    input  produto, busy, pronto, erro_seq
  );

  // Multiplier datapath side.
  modport slave (
    input  start, operando_a, operando_b,
    output produto, busy, pronto, erro_seq
  );

endinterface
`default_nettype wire

// File: rtl/multiplicador_seq_datapath_somador_passo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : somador_passo                                                |
// | Description : One shift-add step: hi + (lo[0] ? mcand : 0), then the       |
// |               {carry,hi,lo} word shifted right by one.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module somador_passo
  import multiplicador_seq_datapath_pkg::*;
(
  input  wire logic [LARGURA-1:0]   i_mcand,
  input  wire logic [LARGURA-1:0]   i_hi,
  input  wire logic [LARGURA-1:0]   i_lo,
  output logic      [2*LARGURA-1:0] o_p_next
);

  logic [LARGURA-1:0] w_parcela;
  logic [LARGURA:0]   w_soma;

  // The multiplier bit currently at P[0] gates the multiplicand into the sum.
  assign w_parcela = i_lo[0] ? i_mcand : '0;
  assign w_soma    = {1'b0, i_hi} + {1'b0, w_parcela};

  // Carry becomes the new MSB; lo[0] has been consumed and drops off.
  assign o_p_next  = {w_soma, i_lo[LARGURA-1:1]};

endmodule
`default_nettype wire

// File: rtl/multiplicador_seq_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multiplicador_seq_datapath                                   |
// | Description : Unsigned shift-add multiplier datapath with step counter,    |
// |               driven by external decoder strobes, with sequence checking.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multiplicador_seq_datapath
  import multiplicador_seq_datapath_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst_n,
  multiplicador_seq_datapath_if.slave bus,
  input  wire logic             load_signal,
  input  wire logic             calc_signal,
  input  wire logic             done_signal,
  output logic      [CNT_W-1:0] contagem
);

  logic [CNT_W-1:0]       r_contagem;
  logic [LARGURA-1:0]     r_mcand;
  logic [2*LARGURA-1:0]   r_p;
  logic [2*LARGURA-1:0]   r_produto;
  logic                   r_pronto;
  logic                   r_erro_seq;

  logic [2*LARGURA-1:0]   w_p_next;
  logic [2:0]             w_strobes;
  logic [2:0]             w_strobes_esperados;
  logic                   w_coerente;

  somador_passo u_somador_passo (
    .i_mcand  (r_mcand),
    .i_hi     (r_p[2*LARGURA-1:LARGURA]),
    .i_lo     (r_p[LARGURA-1:0]),
    .o_p_next (w_p_next)
  );

  assign w_strobes = {load_signal, calc_signal, done_signal};

  // Strobe pattern the decoder must present for the current count; an
  // out-of-range count maps to a pattern no decoder can legally produce.
  always_comb begin
    w_strobes_esperados = 3'b000;
    case (modo_esperado(r_contagem))
      MODO_LOAD: w_strobes_esperados = 3'b100;
      MODO_CALC: w_strobes_esperados = 3'b010;
      MODO_DONE: w_strobes_esperados = 3'b001;
      default:   w_strobes_esperados = 3'b000;
    endcase
  end

  assign w_coerente = (w_strobes == w_strobes_esperados) && (w_strobes_esperados != 3'b000);

  // Counter, operand/partial-product registers, result and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_contagem <= CNT_LOAD;
      r_mcand    <= '0;
      r_p        <= '0;
      r_produto  <= '0;
      r_pronto   <= 1'b0;
      r_erro_seq <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      if (!w_coerente) begin
        // Sequence fault: abort back to LOAD, keep the previous result.
        r_erro_seq <= 1'b1;
        r_contagem <= CNT_LOAD;
      end else if (load_signal) begin
        if (bus.start) begin
          r_mcand    <= bus.operando_a;
          r_p        <= {{LARGURA{1'b0}}, bus.operando_b};
          r_contagem <= CNT_W'(1);
          r_erro_seq <= 1'b0;
        end
      end else if (calc_signal) begin
        r_p        <= w_p_next;
        r_contagem <= r_contagem + CNT_W'(1);
      end else begin
        r_produto  <= r_p;
        r_pronto   <= 1'b1;
        r_contagem <= CNT_LOAD;
      end
    end
  end

  assign contagem     = r_contagem;
  assign bus.produto  = r_produto;
  assign bus.pronto   = r_pronto;
  assign bus.erro_seq = r_erro_seq;
  assign bus.busy     = (r_contagem != CNT_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_seq_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multiplicador_seq_datapath                                |
// | Description : Self-checking bench with the control decoder in the loop.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multiplicador_seq_datapath;
  import multiplicador_seq_datapath_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             load_signal;
  logic             calc_signal;
  logic             done_signal;
  logic [CNT_W-1:0] contagem;
  logic             force_calc_off;

  int checks;
  int errors;
  logic [15:0] model_produto;

  multiplicador_seq_datapath_if bus ();

  multiplicador_seq_datapath dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .load_signal (load_signal),
    .calc_signal (calc_signal),
    .done_signal (done_signal),
    .contagem    (contagem)
  );

  // Control decoder; force_calc_off lets the bench inject a missing strobe.
  assign load_signal = (contagem == CNT_LOAD);
  assign calc_signal = (contagem >= CNT_W'(1)) && (contagem <= CNT_W'(LARGURA)) && !force_calc_off;
  assign done_signal = (contagem == CNT_DONE);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete multiplication starting from an idle LOAD cycle.
  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input bit detail);
    logic [15:0] esperado;
    esperado = 16'(a) * 16'(b);
    bus.operando_a = a;
    bus.operando_b = b;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
    check("accept_cnt", 32'(contagem), 32'd1);
    check("accept_busy", 32'(bus.busy), 32'd1);
    for (int k = 2; k <= 9; k++) begin
      step();
      if (detail) begin
        check("step_cnt", 32'(contagem), 32'(k));
        check("step_pronto", 32'(bus.pronto), 32'd0);
        check("step_produto_held", 32'(bus.produto), 32'(model_produto));
      end
    end
    step();
    check("done_cnt", 32'(contagem), 32'd0);
    check("done_pronto", 32'(bus.pronto), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_produto", 32'(bus.produto), 32'(esperado));
    model_produto = esperado;
    step();
    check("after_pronto", 32'(bus.pronto), 32'd0);
    check("after_produto", 32'(bus.produto), 32'(model_produto));
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    model_produto  = '0;
    force_calc_off = 1'b0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.operando_a = '0;
    bus.operando_b = '0;

    // Reset state
    repeat (2) step();
    check("rst_cnt", 32'(contagem), 32'd0);
    check("rst_produto", 32'(bus.produto), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pronto", 32'(bus.pronto), 32'd0);
    check("rst_erro", 32'(bus.erro_seq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_cnt", 32'(contagem), 32'd0);

    // Directed products
    run_mult(8'd13, 8'd11, 1'b1);
    run_mult(8'd255, 8'd255, 1'b1);
    run_mult(8'd0, 8'd200, 1'b0);
    run_mult(8'd1, 8'd255, 1'b0);

    // start re-asserted mid-operation is ignored
    bus.operando_a = 8'd37;
    bus.operando_b = 8'd91;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
    repeat (3) step();
    check("busy_cnt4", 32'(contagem), 32'd4);
    bus.operando_a = 8'd200;
    bus.operando_b = 8'd3;
    bus.start      = 1'b1;
    repeat (3) step();
    bus.start      = 1'b0;
    repeat (3) step();
    check("ignored_pronto", 32'(bus.pronto), 32'd1);
    check("ignored_produto", 32'(bus.produto), 32'd3367);
    model_produto = 16'd3367;
    step();
    check("ignored_no_queue", 32'(contagem), 32'd0);

    // start held high: back-to-back runs with no skipped LOAD
    bus.start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      bus.operando_a = a;
      bus.operando_b = b;
      step();
      check("b2b_accept_cnt", 32'(contagem), 32'd1);
      for (int k = 0; k < 8; k++) begin
        step();
        check("b2b_no_pronto", 32'(bus.pronto), 32'd0);
      end
      step();
      check("b2b_pronto", 32'(bus.pronto), 32'd1);
      check("b2b_produto", 32'(bus.produto), 32'(16'(a) * 16'(b)));
      model_produto = 16'(a) * 16'(b);
    end
    bus.start = 1'b0;
    step();

    // Asynchronous reset mid-operation
    bus.operando_a = 8'd99;
    bus.operando_b = 8'd77;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
    repeat (4) step();
    check("pre_rst_cnt", 32'(contagem), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(contagem), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_pronto", 32'(bus.pronto), 32'd0);
    check("async_rst_produto", 32'(bus.produto), 32'd0);
    model_produto = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_mult(8'd77, 8'd66, 1'b0);

    // Missing calc strobe at contagem=3
    bus.operando_a = 8'd50;
    bus.operando_b = 8'd60;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
    repeat (2) step();
    check("pre_fault_cnt", 32'(contagem), 32'd3);
    force_calc_off = 1'b1;
    step();
    force_calc_off = 1'b0;
    check("fault_erro", 32'(bus.erro_seq), 32'd1);
    check("fault_cnt", 32'(contagem), 32'd0);
    check("fault_pronto", 32'(bus.pronto), 32'd0);
    step();
    check("fault_sticky", 32'(bus.erro_seq), 32'd1);
    check("fault_no_pronto", 32'(bus.pronto), 32'd0);
    check("fault_produto_held", 32'(bus.produto), 32'(model_produto));
    run_mult(8'd12, 8'd12, 1'b0);
    check("fault_cleared", 32'(bus.erro_seq), 32'd0);

    // Random operand pairs against plain multiplication
    for (int i = 0; i < 1000; i++) begin
      run_mult(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
